// File: rtl/life_window_gen.sv
// life_window_gen: streaming 3x3 neighbourhood generator feeding life_8c.
// Cells arrive one per accepted beat in raster order. A 2*GRID_W+3 cell
// shift register holds two rows plus three cells, which is enough to hold
// every neighbour of the centre cell. Off-grid neighbours are masked to 0
// using the centre row/col counters.
//
// Handshake: a cell is taken on any rising edge where in_valid and in_ready
// are both high; in_ready never depends on in_valid. The output side has
// no backpressure: out_valid is a one-cycle strobe and out_* data holds
// between strobes.
//
// Optional feature: define LIFE_WINDOW_COORD_EN to add out_row/out_col
// ports carrying the centre coordinates of each window.
module life_window_gen #(
  parameter int GRID_W = 8,
  parameter int GRID_H = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_cell,
  output logic       out_valid,
  output logic       out_self,
  output logic [7:0] out_neighbors,
`ifdef LIFE_WINDOW_COORD_EN
  output logic [$clog2(GRID_H)-1:0] out_row,
  output logic [$clog2(GRID_W)-1:0] out_col,
`endif
  output logic       frame_done
);

  localparam int SR_LEN = 2 * GRID_W + 3;
  localparam int CELLS  = GRID_W * GRID_H;
  localparam int IW     = $clog2(CELLS);
  localparam int DW     = $clog2(GRID_W + 1);
  localparam int RW     = $clog2(GRID_H);
  localparam int CW     = $clog2(GRID_W);

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t              state;
  logic [IW-1:0]       in_idx;
  logic [DW-1:0]       drain_cnt;
  logic [RW-1:0]       row_cnt;
  logic [CW-1:0]       col_cnt;
  logic [SR_LEN-1:0]   sr;

  logic                accept;
  logic                shift;
  logic                new_bit;
  logic                emit;
  logic                at_top;
  logic                at_bottom;
  logic                at_left;
  logic                at_right;
  logic [7:0]          nb_raw;
  logic [7:0]          nb_mask;
  logic                self_bit;

  // Shift/emit decisions and the masked window seen after this cycle's shift.
  // sr[0] is the newest cell; after a shift, the centre sits at position
  // GRID_W+1, so reading one position lower than the post-shift layout
  // gives the window directly from the current contents plus new_bit.
  always_comb begin
    accept    = in_valid & in_ready & (state == RUN);
    shift     = accept | (state == DRAIN);
    new_bit   = (state == RUN) ? in_cell : 1'b0;
    emit      = (state == DRAIN) |
                (accept & (in_idx >= IW'(GRID_W + 1)));

    at_top    = (row_cnt == '0);
    at_bottom = (row_cnt == RW'(GRID_H - 1));
    at_left   = (col_cnt == '0);
    at_right  = (col_cnt == CW'(GRID_W - 1));

    self_bit  = sr[GRID_W];
    nb_raw    = 8'h00;
    nb_raw[0] = sr[2 * GRID_W + 1];  // NW
    nb_raw[1] = sr[2 * GRID_W];      // N
    nb_raw[2] = sr[2 * GRID_W - 1];  // NE
    nb_raw[3] = sr[GRID_W + 1];      // W
    nb_raw[4] = sr[GRID_W - 1];      // E
    nb_raw[5] = sr[1];               // SW
    nb_raw[6] = sr[0];               // S
    nb_raw[7] = new_bit;             // SE

    // Mask bits that fall off the grid; the shift register holds
    // adjacent-row data there, so masking is mandatory.
    nb_mask = 8'hFF;
    if (at_top) begin
      nb_mask[0] = 1'b0;
      nb_mask[1] = 1'b0;
      nb_mask[2] = 1'b0;
    end
    if (at_bottom) begin
      nb_mask[5] = 1'b0;
      nb_mask[6] = 1'b0;
      nb_mask[7] = 1'b0;
    end
    if (at_left) begin
      nb_mask[0] = 1'b0;
      nb_mask[3] = 1'b0;
      nb_mask[5] = 1'b0;
    end
    if (at_right) begin
      nb_mask[2] = 1'b0;
      nb_mask[4] = 1'b0;
      nb_mask[7] = 1'b0;
    end
  end

  // RUN/DRAIN state machine with the input index and drain counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      in_ready  <= 1'b1;
      in_idx    <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (accept) begin
            if (in_idx == IW'(CELLS - 1)) begin
              in_idx    <= '0;
              drain_cnt <= '0;
              state     <= DRAIN;
              in_ready  <= 1'b0;
            end else begin
              in_idx <= in_idx + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == DW'(GRID_W)) begin
            drain_cnt <= '0;
            state     <= RUN;
            in_ready  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: begin
          state    <= RUN;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  // Centre row/col counters, advanced once per emitted window.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt <= '0;
      col_cnt <= '0;
    end else if (emit) begin
      if (at_right) begin
        col_cnt <= '0;
        row_cnt <= at_bottom ? '0 : row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  // Cell shift register: input cells in RUN, zeros while draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (shift) begin
      sr <= {sr[SR_LEN-2:0], new_bit};
    end
  end

  // Registered window outputs; data holds between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      frame_done    <= 1'b0;
      out_self      <= 1'b0;
      out_neighbors <= 8'h00;
`ifdef LIFE_WINDOW_COORD_EN
      out_row       <= '0;
      out_col       <= '0;
`endif
    end else begin
      out_valid  <= emit;
      frame_done <= emit & at_bottom & at_right;
      if (emit) begin
        out_self      <= self_bit;
        out_neighbors <= nb_raw & nb_mask;
`ifdef LIFE_WINDOW_COORD_EN
        out_row       <= row_cnt;
        out_col       <= col_cnt;
`endif
      end
    end
  end

endmodule

// File: doc/life_window_gen.md
# life_window_gen

Streaming neighbourhood generator that sits directly upstream of `life_8c`. It accepts a Game-of-Life grid one cell per accepted beat in raster order (row 0 col 0 first). For every cell it emits the cell itself (`out_self`) and its eight neighbours (`out_neighbors`), ready to drive `life_8c` `self`/`neighbors`. Off-grid neighbours read as dead (0). Storage is a shift register of 2·GRID_W+3 cells.

## Interface
- `GRID_W`, 8, grid columns; minimum 3.
- `GRID_H`, 8, grid rows; minimum 3.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  `in_cell` is valid this cycle.
- `in_ready`  out  1  block accepts a cell this cycle. Accept = `in_valid & in_ready`.
- `in_cell`  in  1  cell state, 1 = alive.
- `out_valid`  out  1  one-cycle strobe; output window is valid.
- `out_self`  out  1  centre cell.
- `out_neighbors`  out  8  bit order: [0]=NW, [1]=N, [2]=NE, [3]=W, [4]=E, [5]=SW, [6]=S, [7]=SE.
- `frame_done`  out  1  one-cycle strobe on the last window of a frame.

## Operation
- State machine:
  - RUN (reset state): `in_ready`=1.
  - DRAIN: `in_ready`=0.
- Transitions:
  - RUN→DRAIN on the accept of cell index GRID_W·GRID_H−1.
  - DRAIN→RUN after exactly GRID_W+1 drain cycles.
- Shift register:
  - Shifts on each accept in RUN, inserting `in_cell`.
  - Shifts on every DRAIN cycle, inserting 0.
  - Holds when there is no accept in RUN.
- Counters:
  - Input index counter 0..GRID_W·GRID_H−1.
  - Output row/col counters track the centre cell; col wraps at GRID_W−1, and row increments on that wrap.
- Output emission: a window for centre index k is produced on the shift that inserts index k+GRID_W+1 (a drain shift counts). The first GRID_W+1 accepts of a frame produce no window.
- Edge masking:
  - Row 0: NW, N, NE forced to 0.
  - Row GRID_H−1: SW, S, SE forced to 0.
  - Col 0: NW, W, SW forced to 0.
  - Col GRID_W−1: NE, E, SE forced to 0.
  - Masking applies even though the shift register holds adjacent-row data. There is no wrap-around.
- Exactly GRID_W·GRID_H `out_valid` strobes per frame. `frame_done` coincides with the strobe for centre (GRID_H−1, GRID_W−1).
- After DRAIN, all counters are at 0. The next frame starts with no idle cycle required.
- `rst` asserted in any state, including mid-frame or mid-drain:
  - Clears the shift register, counters and state.
  - Discards the partial frame.
  - `in_ready` reads 1 on the first cycle after reset.

## Timing
- Reset values:
  - `in_ready`=1.
  - `out_valid`=0, `out_self`=0, `out_neighbors`=8'h00, `frame_done`=0.
  - `out_row`/`out_col` (if present)=0.
- All outputs are registered. The window for centre k appears the cycle after the accept (or drain cycle) that inserts index k+GRID_W+1.
- Latency from accept of centre k to its window = GRID_W+2 cycles when there are no input gaps.
- Input gaps (`in_valid`=0 in RUN): no shift, no `out_valid`. Window contents are unaffected by gaps.
- `out_*` data holds its last value when `out_valid`=0.
- DRAIN lasts GRID_W+1 cycles with back-to-back `out_valid`. `in_valid` during DRAIN is ignored (not accepted).
- No output backpressure: downstream must take one window per cycle.

## Configuration
- Macro: `LIFE_WINDOW_COORD_EN`.
- Defined: adds ports `out_row` (width $clog2(GRID_H)) and `out_col` (width $clog2(GRID_W)), both outputs. They carry the centre cell coordinates, registered alongside `out_valid`.
- Undefined: those ports and their registers are absent. Internal masking counters remain. All other behaviour is identical.

## Test plan
- Reset: hold `rst` 2 cycles → all outputs at reset values, `in_ready`=1. Drive `in_valid`=0 for 5 cycles → no `out_valid`.
- 8×8 grid, single live cell at (3,3), stream without gaps:
  - Window (2,2): `out_neighbors`=8'b1000_0000.
  - Window (4,4): 8'b0000_0001.
  - Window (3,3): `out_self`=1, neighbours 0.
  - 64 strobes total.
- 8×8 all-ones grid:
  - (0,0) → 8'b1101_0000.
  - (0,7) → 8'b0110_1000.
  - (7,7) → 8'b0000_1011.
  - (3,3) → 8'hFF.
  - No wrap into the opposite edge.
- Random `in_valid` gaps (~50%) on a random 8×8 frame → window sequence identical to the gapless run, and no `out_valid` during gaps.
- Drain and back-to-back frames:
  - After the 64th accept, `in_ready`=0 for exactly 9 cycles with 9 consecutive `out_valid`.
  - `frame_done` fires with window (7,7).
  - A second frame is accepted the cycle after and produces 64 correct windows.
- Reset mid-frame after 20 accepts, then a full fresh frame → no stale window. First window (0,0) reflects only the new data. With `LIFE_WINDOW_COORD_EN` defined, `out_row`/`out_col` = 0/0 on it.
